// File: rtl/uart_mem_loader.sv
// uart_mem_loader: serial boot/download engine.
//
// Receives 8N1 frames on ser_rxd and writes 32-bit words into the shared
// instruction/data memory through the same port the core uses. pause_o holds
// the core off while a frame is in progress.
//
// Frame: SYNC_BYTE | ADDR[4] (MSB first) | LEN[2] (MSB first, word count N)
//        | DATA[N*4] (MSB first per word) | CSUM[1]
// The sum of all ADDR, LEN, DATA and CSUM bytes must be 0 mod 256.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   ser_rxd  serial input, 8N1, idle high
//   ser_txd  serial output (ACK/NAK when UART_LOADER_ACK_EN, else constant 1)
//   pause_o  core pause request, high while a frame is in progress
//   addr_o   memory write address (word aligned)
//   dout     memory write data
//   wr_en_o  byte write enables, 4'b1111 for one cycle per word
//   done_o   one-cycle pulse at the end of a good frame
//   err_o    sticky error flag, cleared by reset or the next SYNC_BYTE
//
// Optional feature macro: UART_LOADER_ACK_EN
//   defined   -> 8N1 transmitter answers 8'h06 (good frame) or 8'h15
//                (checksum error, framing error, timeout)
//   undefined -> no transmitter, ser_txd tied high
//
// FSM states:
//   state  | meaning
//   IDLE   | waiting for SYNC_BYTE, core running
//   ADDR   | collecting 4 address bytes
//   LEN    | collecting 2 word-count bytes
//   DATA   | collecting data words, one write per 4 bytes
//   CSUM   | waiting for the checksum byte
//   DONE   | one-cycle done pulse, then back to IDLE

module uart_mem_loader #(
  parameter int unsigned CLK_DIV   = 434,
  parameter int unsigned TIMEOUT   = 1000000,
  parameter logic [7:0]  SYNC_BYTE = 8'h55
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ser_rxd,
  output logic        ser_txd,
  output logic        pause_o,
  output logic [31:0] addr_o,
  output logic [31:0] dout,
  output logic [3:0]  wr_en_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned HALF_RAW = CLK_DIV / 2;
  localparam logic [15:0] BIT_M1   = 16'(CLK_DIV - 1);
  // Half a bit, less the ~3 cycles already spent in the synchronizer and
  // edge detector, so the start bit is sampled close to its centre.
  localparam logic [15:0] RX_HALF  = (HALF_RAW > 3) ? 16'(HALF_RAW - 3) : 16'd0;
  localparam logic [23:0] TMO_M1   = 24'(TIMEOUT - 1);

  // ---------------------------------------------------------------------
  // RX front end
  // ---------------------------------------------------------------------
  logic        rxd_meta, rxd_sync, rxd_prev;
  logic        rx_busy;
  logic [15:0] rx_timer;
  logic [3:0]  rx_bit;
  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        frame_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta   <= 1'b1;
      rxd_sync   <= 1'b1;
      rxd_prev   <= 1'b1;
      rx_busy    <= 1'b0;
      rx_timer   <= '0;
      rx_bit     <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rxd_meta   <= ser_rxd;
      rxd_sync   <= rxd_meta;
      rxd_prev   <= rxd_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!rx_busy) begin
        if (rxd_prev && !rxd_sync) begin
          rx_busy  <= 1'b1;
          rx_timer <= RX_HALF;
          rx_bit   <= '0;
        end
      end else if (rx_timer != '0) begin
        rx_timer <= rx_timer - 16'd1;
      end else begin
        rx_timer <= BIT_M1;
        rx_bit   <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          // start bit went high again: line glitch, quietly resume idle
          if (rxd_sync) rx_busy <= 1'b0;
        end else if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
          if (rxd_sync) byte_valid <= 1'b1;
          else          frame_err  <= 1'b1;
        end else begin
          rx_byte <= {rxd_sync, rx_byte[7:1]};
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DONE
  } state_t;

  state_t      state, state_next;
  logic [1:0]  byte_cnt;
  logic [31:0] addr_reg;
  logic [15:0] len_cnt;
  logic [23:0] word_reg;
  logic [7:0]  csum;
  logic [7:0]  csum_sum;
  logic [23:0] tmo_cnt;
  logic        timeout;
  logic        csum_bad;

  assign csum_sum = csum + rx_byte;
  assign pause_o  = (state != S_IDLE);
  assign done_o   = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    csum_bad   = 1'b0;
    if (state != S_IDLE && tmo_cnt == '0 && !byte_valid) timeout = 1'b1;
    case (state)
      S_IDLE: if (byte_valid && rx_byte == SYNC_BYTE) state_next = S_ADDR;
      S_ADDR: if (byte_valid && byte_cnt == 2'd3) state_next = S_LEN;
      S_LEN:  if (byte_valid && byte_cnt == 2'd1)
                state_next = ({len_cnt[7:0], rx_byte} != 16'd0) ? S_DATA : S_CSUM;
      S_DATA: if (byte_valid && byte_cnt == 2'd3 && len_cnt == 16'd1) state_next = S_CSUM;
      S_CSUM: if (byte_valid) begin
                if (csum_sum == 8'd0) begin
                  state_next = S_DONE;
                end else begin
                  csum_bad   = 1'b1;
                  state_next = S_IDLE;
                end
              end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (state != S_IDLE && (frame_err || timeout)) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
      addr_reg <= '0;
      len_cnt  <= '0;
      word_reg <= '0;
      csum     <= '0;
      tmo_cnt  <= '0;
      err_o    <= 1'b0;
      addr_o   <= '0;
      dout     <= '0;
      wr_en_o  <= '0;
    end else begin
      wr_en_o <= '0;

      if (state == S_IDLE || byte_valid) tmo_cnt <= TMO_M1;
      else if (tmo_cnt != '0)            tmo_cnt <= tmo_cnt - 24'd1;

      if (csum_bad || timeout || frame_err)
        err_o <= 1'b1;
      else if (state == S_IDLE && byte_valid && rx_byte == SYNC_BYTE)
        err_o <= 1'b0;

      case (state)
        S_IDLE: begin
          byte_cnt <= '0;
          csum     <= '0;
        end
        S_ADDR: if (byte_valid) begin
          csum     <= csum_sum;
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) addr_reg <= {addr_reg[23:0], rx_byte[7:2], 2'b00};
          else                  addr_reg <= {addr_reg[23:0], rx_byte};
        end
        S_LEN: if (byte_valid) begin
          csum     <= csum_sum;
          len_cnt  <= {len_cnt[7:0], rx_byte};
          byte_cnt <= (byte_cnt == 2'd1) ? 2'd0 : 2'd1;
        end
        S_DATA: if (byte_valid) begin
          csum     <= csum_sum;
          byte_cnt <= byte_cnt + 2'd1;
          word_reg <= {word_reg[15:0], rx_byte};
          if (byte_cnt == 2'd3) begin
            addr_o   <= addr_reg;
            dout     <= {word_reg, rx_byte};
            wr_en_o  <= 4'b1111;
            addr_reg <= addr_reg + 32'd4;
            len_cnt  <= len_cnt - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Optional ACK/NAK transmitter
  // ---------------------------------------------------------------------
`ifdef UART_LOADER_ACK_EN
  logic        ack_ev;
  logic [7:0]  ack_byte;
  logic        hold_valid;
  logic [7:0]  hold_byte;
  logic        tx_busy;
  logic        tx_load;
  logic [15:0] tx_timer;
  logic [3:0]  tx_bits;
  logic [8:0]  tx_shift;

  assign ack_ev   = (state == S_DONE) || csum_bad || frame_err || timeout;
  assign ack_byte = (state == S_DONE) ? 8'h06 : 8'h15;
  assign tx_load  = !tx_busy && hold_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid <= 1'b0;
      hold_byte  <= '0;
      tx_busy    <= 1'b0;
      tx_timer   <= '0;
      tx_bits    <= '0;
      tx_shift   <= '1;
      ser_txd    <= 1'b1;
    end else begin
      // a newer response replaces the queued one; the shifter is separate,
      // so a byte already on the wire is never touched
      if (ack_ev) begin
        hold_byte  <= ack_byte;
        hold_valid <= 1'b1;
      end else if (tx_load) begin
        hold_valid <= 1'b0;
      end

      if (tx_load) begin
        tx_busy  <= 1'b1;
        tx_shift <= {1'b1, hold_byte};
        tx_bits  <= 4'd9;
        tx_timer <= BIT_M1;
        ser_txd  <= 1'b0;
      end else if (tx_busy) begin
        if (tx_timer != '0) begin
          tx_timer <= tx_timer - 16'd1;
        end else if (tx_bits == 4'd0) begin
          tx_busy <= 1'b0;
        end else begin
          ser_txd  <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_bits  <= tx_bits - 4'd1;
          tx_timer <= BIT_M1;
        end
      end
    end
  end
`else
  assign ser_txd = 1'b1;
`endif

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Serial boot/download engine: receives framed bytes on ser_rxd and writes 32-bit words into the shared instruction/data memory array.
- Holds the CPU core paused while it loads.
- Writer-side counterpart to the core's fetch/load path: drives the same address/data/4-bit byte-write-enable memory port the core drives, muxed in by the top level while pause_o is high.

Parameters:
- CLK_DIV, 434, clk cycles per serial bit (50 MHz / 115200); legal range 4..65535.
- TIMEOUT, 1000000, idle clk cycles mid-frame before abort; legal range 16..2^24-1.
- SYNC_BYTE, 8'h55, frame start marker.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ser_rxd  in  1  serial input, 8N1, idle high.
- ser_txd  out  1  serial output; constant 1 unless UART_LOADER_ACK_EN.
- pause_o  out  1  core pause request; high while a frame is in progress.
- addr_o  out  32  memory write address, word aligned.
- dout  out  32  memory write data.
- wr_en_o  out  4  byte write enables; 4'b1111 for one cycle per word, else 0.
- done_o  out  1  one-cycle pulse at end of a good frame.
- err_o  out  1  sticky error flag; cleared by reset or by the next SYNC_BYTE.

Behaviour:
- Reset (rst=0, async): all outputs 0 except ser_txd=1; FSM in IDLE; counters 0.
- RX front end:
  - 2-FF synchronizer on ser_rxd.
  - Start condition: falling edge of the synced line.
  - Start bit re-sampled at CLK_DIV/2; if high, it is a glitch: return to line idle, no error.
  - Data bits sampled every CLK_DIV thereafter, LSB first.
  - Stop bit sampled at bit 9. Stop=0 is a framing error: byte dropped, err_o=1, FSM to IDLE.
  - A good byte produces an internal 1-cycle byte_valid.
- Frame format, in order:
  - SYNC_BYTE.
  - ADDR: 4 bytes, MSB first.
  - LEN: 2 bytes, MSB first, word count N.
  - DATA: N words, 4 bytes each, MSB first.
  - CSUM: 1 byte.
- FSM states and transitions:
  - IDLE: on byte==SYNC_BYTE → ADDR; pause_o=1, err_o=0, checksum accumulator=0. Other bytes are ignored.
  - ADDR: after 4 bytes → LEN. Address register low 2 bits forced to 00.
  - LEN: after 2 bytes → DATA if N>0, else CSUM.
  - DATA: on the 4th byte of each word, in the next cycle: addr_o=current address, dout=assembled word, wr_en_o=4'b1111 for exactly one cycle. Then address += 4 (wraps modulo 2^32); word count -1. When the count reaches 0 → CSUM.
  - CSUM: on byte arrival → DONE if (sum of all ADDR, LEN, DATA bytes + CSUM byte) mod 256 == 0; else err_o=1 → IDLE.
  - DONE: done_o=1 for one cycle; → IDLE.
- pause_o: rises the cycle after SYNC_BYTE is accepted; falls the cycle after leaving CSUM or DONE, or on any abort.
  - Its last write pulse always occurs while pause_o=1.
- Checksum failure does not undo completed writes; host must resend.
- Timeout: in any state except IDLE, TIMEOUT cycles with no byte_valid → err_o=1, IDLE, pause_o=0.
- Write pulses are spaced at least 4 byte times apart; the memory port never sees back-to-back writes.
- SYNC_BYTE value received inside a frame is treated as payload, not as a resync.
- Reset mid-frame: immediate return to reset values; any partial word is discarded.

Optional Feature:
- UART_LOADER_ACK_EN defined:
  - 8N1 transmitter at the same CLK_DIV on ser_txd.
  - Sends 8'h06 after DONE and 8'h15 after a checksum error, framing error or timeout.
  - Byte is queued in a 1-deep holding register. A new response arriving while one is still sending overwrites the queued byte; the in-flight byte is never corrupted.
  - pause_o is unaffected by transmission.
- Undefined: no transmitter logic; ser_txd tied to 1.

Test Plan (bench with CLK_DIV=8, TIMEOUT=200):
- Reset check: rst=0 mid-run → outputs 0, ser_txd=1, pause_o=0, asynchronously without a clk edge.
- Good frame 55 | 00 00 01 00 | 00 02 | DE AD BE EF | 01 23 45 67 | CSUM → writes:
  - addr 0x100 data 0xDEADBEEF; addr 0x104 data 0x01234567; each wr_en=1111 for 1 cycle.
  - Then done_o pulse, pause_o falls, err_o=0.
  - With ACK_EN, ser_txd carries 0x06.
- Same frame with CSUM+1 → both writes still occur; err_o=1, no done_o; with ACK_EN, 0x15.
- LEN=0, addr 0x00000003: no write pulses, done_o pulse, err_o=0.
- Frame starting at addr 0xFFFFFFFC, N=2 → writes at 0xFFFFFFFC then 0x00000000.
- Stop bit forced 0 on the second DATA byte → err_o=1, pause_o=0, no write.
- Stall after the ADDR bytes for 250 cycles → timeout abort: err_o=1, pause_o=0.
- A following SYNC_BYTE clears err_o.
